// File: rtl/block_mem_responder_pkg.sv
// Shared definitions for the block memory responder: default widths, block size,
// wait-counter width and the FSM state encoding used by the cache/control pair.
package block_mem_responder_pkg;

    localparam int DEF_ADDR_W      = 15;
    localparam int DEF_DATA_W      = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/block_mem_responder_if.sv
// Block-refill bus between the cache controller (master) and main memory (slave).
interface block_mem_responder_if
    import block_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              read;
    logic [ADDR_W-1:0] adr;
    logic              done;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] data3;
    logic [DATA_W-1:0] data4;

    modport master (
        output read, adr,
        input  done, data1, data2, data3, data4
    );

    modport slave (
        input  read, adr,
        output done, data1, data2, data3, data4
    );

endinterface

// File: rtl/block_mem_responder_mem_array.sv
// Main-memory storage with a 4-word combinational read at a block-aligned base.
module mem_array
    import block_mem_responder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0]                      base,
    output logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] words
);

    localparam int IDX_W = $clog2(DEPTH);

    // The array has no write path, so every word keeps its initial value mem[i] = i
    // and a read reduces to zero-extending the word index.
    function automatic logic [DATA_W-1:0] init_word(input logic [IDX_W-1:0] idx);
        init_word = DATA_W'(idx);
    endfunction

    always_comb begin
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            words[w] = init_word(IDX_W'(base) + IDX_W'(w));
        end
    end

endmodule

// File: rtl/block_mem_responder.sv
// Single-clock main-memory responder: accepts a block read, waits LATENCY cycles,
// returns a 4-word block with a 4-phase read/done handshake and counts completed reads.
module block_mem_responder
    import block_mem_responder_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = 5,
    parameter int DEPTH   = 2**ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    block_mem_responder_if.slave  bus,
    output logic                  busy,
    output logic [ADDR_W-1:0]     rd_count
);

    state_t                                 state;
    state_t                                 next_state;
    logic [CNT_W-1:0]                       wait_cnt;
    logic [ADDR_W-1:0]                      base;
    logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] blk_words;
    logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] data_q;
    logic                                   done;
    logic                                   accept;
    logic                                   finish;

    assign accept = (state == S_IDLE) && bus.read;
    assign finish = (state == S_WAIT) && bus.read && (wait_cnt == '0);

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .base  (base),
        .words (blk_words)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (bus.read) next_state = S_WAIT;
            S_WAIT: begin
                if (!bus.read)            next_state = S_IDLE;
                else if (wait_cnt == '0)  next_state = S_DONE;
            end
            S_DONE: if (!bus.read) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // done and busy are pure decodes of the registered state, so they change only on edges.
    always_comb begin
        done = (state == S_DONE);
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            base     <= '0;
            data_q   <= '0;
            rd_count <= '0;
        end else begin
            if (accept) begin
                base     <= bus.adr & ~ADDR_W'(WORDS_PER_BLOCK - 1);
                wait_cnt <= CNT_W'(LATENCY - 1);
            end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (finish) begin
                data_q   <= blk_words;
                rd_count <= rd_count + 1'b1;
            end
        end
    end

    assign bus.done  = done;
    assign bus.data1 = data_q[0];
    assign bus.data2 = data_q[1];
    assign bus.data3 = data_q[2];
    assign bus.data4 = data_q[3];

endmodule

// File: tb/tb_block_mem_responder.sv
// Scoreboard bench for block_mem_responder: directed block reads, aborts, async resets, sweep.
module tb_block_mem_responder;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int LAT    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              busy;
    logic [ADDR_W-1:0] rd_count;

    always #5 clk = ~clk;

    block_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    block_mem_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LATENCY (LAT),
        .DEPTH   (32768)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .rd_count (rd_count)
    );

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] cnt;
    } exp_t;

    exp_t              sb[$];
    exp_t              me;
    int                total = 0;
    int                bad   = 0;
    int                cyc   = 0;
    logic [ADDR_W-1:0] exp_cnt;
    logic              done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every rising done must match the oldest expected block.
    always @(negedge clk) begin
        if (bus.done && !done_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                me = sb.pop_front();
                check("latency_cycle", 64'(cyc), 64'(me.cyc));
                check("data1", 64'(bus.data1), 64'(me.base) + 64'd0);
                check("data2", 64'(bus.data2), 64'(me.base) + 64'd1);
                check("data3", 64'(bus.data3), 64'(me.base) + 64'd2);
                check("data4", 64'(bus.data4), 64'(me.base) + 64'd3);
                check("rd_count", 64'(rd_count), 64'(me.cnt));
            end
        end
        done_prev = bus.done;
    end

    task automatic block_read(input logic [ADDR_W-1:0] a, input int hold, input bit scramble);
        logic [ADDR_W-1:0] b;
        int                k;
        b = a & 15'h7FFC;
        @(negedge clk);
        bus.adr  = a;
        bus.read = 1'b1;
        exp_cnt  = exp_cnt + 1'b1;
        sb.push_back('{cyc + 1 + LAT, b, exp_cnt});
        k = 0;
        while (!bus.done && k < LAT + 4) begin
            @(negedge clk);
            k++;
            if (scramble) bus.adr = 15'd5;
        end
        if (!bus.done) check("done_timeout", 64'd0, 64'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_done", 64'(bus.done), 64'd1);
            check("hold_data1", 64'(bus.data1), 64'(b));
            check("hold_data4", 64'(bus.data4), 64'(b) + 64'd3);
        end
        bus.read = 1'b0;
        @(negedge clk);
        check("drop_done", 64'(bus.done), 64'd0);
        check("drop_busy", 64'(busy), 64'd0);
        check("keep_data2", 64'(bus.data2), 64'(b) + 64'd1);
    endtask

    // Mid-cycle reset pulse; outputs must clear before the next clock edge.
    task automatic reset_pulse(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_data1"}, 64'(bus.data1), 64'd0);
        check({tag, "_data4"}, 64'(bus.data4), 64'd0);
        check({tag, "_rd_count"}, 64'(rd_count), 64'd0);
        bus.read = 1'b0;
        #1 rst = 1'b0;
        exp_cnt = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        bus.read = 1'b0;
        bus.adr  = '0;
        exp_cnt  = '0;
        #20;
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_count", 64'(rd_count), 64'd0);
        check("rst_data1", 64'(bus.data1), 64'd0);
        #80 rst = 1'b0;

        // Basic block read, then unaligned address with adr changed during WAIT.
        block_read(15'd1024, 0, 1'b0);
        block_read(15'd1030, 0, 1'b1);

        // Abort after two WAIT edges.
        @(negedge clk);
        bus.adr  = 15'd2000;
        bus.read = 1'b1;
        @(negedge clk);
        check("abort_busy_hi", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        bus.read = 1'b0;
        @(negedge clk);
        check("abort_busy_lo", 64'(busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_rd_count", 64'(rd_count), 64'(exp_cnt));
        repeat (LAT + 2) @(negedge clk);
        check("abort_no_done", 64'(bus.done), 64'd0);

        // Long hold in DONE, then an immediate re-request.
        block_read(15'd3000, 10, 1'b0);
        block_read(15'd4097, 0, 1'b0);

        // Reset while in WAIT.
        @(negedge clk);
        bus.adr  = 15'd100;
        bus.read = 1'b1;
        repeat (2) @(negedge clk);
        check("wait_busy", 64'(busy), 64'd1);
        reset_pulse("rst_in_wait");

        // Reset while in DONE.
        @(negedge clk);
        bus.adr  = 15'd200;
        bus.read = 1'b1;
        exp_cnt  = exp_cnt + 1'b1;
        sb.push_back('{cyc + 1 + LAT, 15'd200, exp_cnt});
        repeat (LAT + 1) @(negedge clk);
        check("pre_rst_done", 64'(bus.done), 64'd1);
        reset_pulse("rst_in_done");

        // Top block of memory.
        block_read(15'd32767, 0, 1'b0);
        @(negedge clk);
        reset_pulse("rst_before_sweep");

        for (int a = 1024; a < 9216; a += 4) begin
            block_read(ADDR_W'(a), 0, 1'b0);
        end
        check("sweep_rd_count", 64'(rd_count), 64'd2048);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
